// File: rtl/st2_ctrl_pkg.sv
// st2_ctrl_pkg: opcode, extender, ALU and state encodings for the stage-2 decode controller
package st2_ctrl_pkg;
  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_BGT   = 4'b0100;
  localparam logic [3:0] OP_BLT   = 4'b0101;
  localparam logic [3:0] OP_BEQ   = 4'b0110;
  localparam logic [3:0] OP_ANDI  = 4'b1000;
  localparam logic [3:0] OP_ORI   = 4'b1001;
  localparam logic [3:0] OP_LW    = 4'b1010;
  localparam logic [3:0] OP_SW    = 4'b1011;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_HALT  = 4'b1111;
  localparam logic [3:0] FN_ADD  = 4'b0000;
  localparam logic [3:0] FN_SUB  = 4'b0001;
  localparam logic [3:0] FN_MULT = 4'b0100;
  localparam logic [3:0] FN_DIV  = 4'b0101;
  localparam logic [1:0] SE_ZX8  = 2'b00;
  localparam logic [1:0] SE_SX4  = 2'b01;
  localparam logic [1:0] SE_SX8  = 2'b10;
  localparam logic [1:0] SE_SX12 = 2'b11;
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_MUL = 3'd4;
  localparam logic [2:0] ALU_DIV = 3'd5;
  typedef enum logic [1:0] {RUN, MD_WAIT, HALT} state_t;
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic [2:0] alu_op;
  } ctrl_t;
  localparam ctrl_t BUBBLE = '0;
endpackage

// File: rtl/st2_hazard_detect.sv
// st2_hazard_detect: load-use compare of the ID/EX load destination against decoded sources
module st2_hazard_detect #(
  parameter int REG_AW = 4
) (
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] src1,
  input  logic [REG_AW-1:0] src2,
  input  logic              use1,
  input  logic              use2,
  output logic              hazard
);
  assign hazard = ex_mem_read && ((use1 && ex_rd == src1) || (use2 && ex_rd == src2));
endmodule

// File: rtl/st2_decode_ctrl.sv
// st2_decode_ctrl: stage-2 decode, ID/EX control register, hazard/flush, mult/div sequencing, HALT.
// Optional macro ST2_ILLEGAL_TRAP_EN: undefined opcodes set sticky illegal and halt.
module st2_decode_ctrl
  import st2_ctrl_pkg::*;
#(
  parameter int MD_CYCLES = 8,
  parameter int REG_AW    = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [15:0]       instr,
  input  logic              if_id_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              branch_cond,
  output logic [1:0]        se_sel,
  output logic              reg_write,
  output logic              mem_read,
  output logic              mem_write,
  output logic              alu_src,
  output logic [2:0]        alu_op,
  output logic              stall,
  output logic              flush,
  output logic              md_start,
  output logic              md_op,
  output logic              halted,
  output logic              illegal
);
  localparam int CW = $clog2(MD_CYCLES + 1);
  logic [3:0] opc, fn;
  logic is_r, is_alu_r, is_md, is_imm, is_lw, is_sw, is_br, is_jmp, is_halt, defined;
  logic use1, use2, hazard, stall_c, flush_c, start_c;
  ctrl_t dec, ctrl_d, ctrl_q;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  assign opc      = instr[15:12];
  assign fn       = instr[3:0];
  assign is_r     = opc == OP_RTYPE;
  assign is_alu_r = is_r && (fn == FN_ADD || fn == FN_SUB);
  assign is_md    = is_r && (fn == FN_MULT || fn == FN_DIV);
  assign is_imm   = opc == OP_ANDI || opc == OP_ORI;
  assign is_lw    = opc == OP_LW;
  assign is_sw    = opc == OP_SW;
  assign is_br    = opc == OP_BGT || opc == OP_BLT || opc == OP_BEQ;
  assign is_jmp   = opc == OP_JMP;
  assign is_halt  = opc == OP_HALT;
  assign defined  = is_alu_r || is_md || is_imm || is_lw || is_sw || is_br || is_jmp || is_halt;
  assign use1     = is_alu_r || is_md || is_br || is_sw;
  assign use2     = use1 || is_lw || is_imm;
  assign se_sel   = (is_lw || is_sw) ? SE_SX4 : is_br ? SE_SX8 : is_jmp ? SE_SX12 : SE_ZX8;
  // Branches and jumps carry no writes, so they fall out of the decode as bubbles.
  assign dec.reg_write = is_alu_r || is_imm || is_lw;
  assign dec.mem_read  = is_lw;
  assign dec.mem_write = is_sw;
  assign dec.alu_src   = is_imm || is_lw || is_sw;
  assign dec.alu_op    = (is_alu_r && fn == FN_SUB) ? ALU_SUB :
                         opc == OP_ANDI ? ALU_AND : opc == OP_ORI ? ALU_OR : ALU_ADD;
  st2_hazard_detect #(.REG_AW(REG_AW)) u_hazard (
    .ex_mem_read(ex_mem_read),
    .ex_rd      (ex_rd),
    .src1       (REG_AW'(instr[11:8])),
    .src2       (REG_AW'(instr[7:4])),
    .use1       (use1),
    .use2       (use2),
    .hazard     (hazard)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl_d  = BUBBLE;
    stall_c = 1'b0;
    flush_c = 1'b0;
    start_c = 1'b0;
    case (state_q)
      RUN: if (if_id_valid) begin
        if (hazard) stall_c = 1'b1;
        else if (is_md) begin
          start_c = 1'b1;
          stall_c = 1'b1;
          state_d = MD_WAIT;
          cnt_d   = CW'(1);
        end
        else if (is_halt) state_d = HALT;
`ifdef ST2_ILLEGAL_TRAP_EN
        else if (!defined) state_d = HALT;
`endif
        else begin
          ctrl_d  = dec;
          flush_c = is_jmp || (is_br && branch_cond);
        end
      end
      // IF/ID is held throughout, so the MD instruction is still in instr at issue.
      MD_WAIT: if (cnt_q == CW'(MD_CYCLES)) begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_op    = fn[0] ? ALU_DIV : ALU_MUL;
        state_d          = RUN;
        cnt_d            = '0;
      end else begin
        stall_c = 1'b1;
        cnt_d   = cnt_q + 1'b1;
      end
      HALT:    stall_c = 1'b1;
      default: state_d = RUN;
    endcase
  end
  always_ff @(posedge clk)
    if (!reset_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      ctrl_q  <= BUBBLE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
    end
`ifdef ST2_ILLEGAL_TRAP_EN
  logic illegal_q;
  always_ff @(posedge clk)
    if (!reset_n) illegal_q <= 1'b0;
    else if (state_q == RUN && if_id_valid && !hazard && !defined) illegal_q <= 1'b1;
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif
  assign {reg_write, mem_read, mem_write, alu_src, alu_op} = ctrl_q;
  assign stall    = reset_n && stall_c;
  assign flush    = reset_n && flush_c;
  assign md_start = reset_n && start_c;
  assign md_op    = md_start && fn[0];
  assign halted   = state_q == HALT;
endmodule

// File: tb/tb_st2_decode_ctrl.sv
// tb_st2_decode_ctrl: table-driven directed bench for st2_decode_ctrl plus multi-cycle sequences
module tb_st2_decode_ctrl;
  logic clk = 1'b0, reset_n, if_id_valid, ex_mem_read, branch_cond;
  logic [15:0] instr;
  logic [3:0] ex_rd;
  logic [1:0] se_sel;
  logic reg_write, mem_read, mem_write, alu_src, stall, flush, md_start, md_op, halted, illegal;
  logic [2:0] alu_op;
  int n_chk = 0, n_fail = 0;

  st2_decode_ctrl #(.MD_CYCLES(8), .REG_AW(4)) dut (
    .clk(clk), .reset_n(reset_n), .instr(instr), .if_id_valid(if_id_valid),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .branch_cond(branch_cond), .se_sel(se_sel),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write), .alu_src(alu_src),
    .alu_op(alu_op), .stall(stall), .flush(flush), .md_start(md_start), .md_op(md_op),
    .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst_n; logic [15:0] ins; logic v, mr; logic [3:0] rd; logic bc;
    logic [1:0] se; logic st, fl, ms; logic [6:0] ctl;
  } vec_t;
  vec_t tbl[20];

  function automatic logic [6:0] ctl();
    return {reg_write, mem_read, mem_write, alu_src, alu_op};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic [15:0] i, input logic v, input logic mr,
                       input logic [3:0] rd, input logic bc);
    reset_n = r; instr = i; if_id_valid = v; ex_mem_read = mr; ex_rd = rd; branch_cond = bc;
  endtask

  task automatic edge_sync();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b0, 16'hC123, 1'b1, 1'b0, 4'd0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 7'b0000000};
    tbl[1]  = '{1'b0, 16'h0124, 1'b1, 1'b1, 4'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 7'b0000000};
    tbl[2]  = '{1'b1, 16'h83F5, 1'b1, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 7'b1001010};
    tbl[3]  = '{1'b1, 16'h9120, 1'b1, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 7'b1001011};
    tbl[4]  = '{1'b1, 16'hA214, 1'b1, 1'b0, 4'd0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 7'b1101000};
    tbl[5]  = '{1'b1, 16'hB356, 1'b1, 1'b0, 4'd0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 7'b0011000};
    tbl[6]  = '{1'b1, 16'h0120, 1'b1, 1'b1, 4'd2, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 7'b0000000};
    tbl[7]  = '{1'b1, 16'h0120, 1'b1, 1'b0, 4'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 7'b1000000};
    tbl[8]  = '{1'b1, 16'h0341, 1'b1, 1'b1, 4'd9, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 7'b1000001};
    tbl[9]  = '{1'b1, 16'hA560, 1'b1, 1'b1, 4'd5, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 7'b1101000};
    tbl[10] = '{1'b1, 16'h8560, 1'b1, 1'b1, 4'd6, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 7'b0000000};
    tbl[11] = '{1'b1, 16'hB780, 1'b1, 1'b1, 4'd7, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 7'b0000000};
    tbl[12] = '{1'b1, 16'h6120, 1'b1, 1'b0, 4'd0, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 7'b0000000};
    tbl[13] = '{1'b1, 16'h6120, 1'b1, 1'b0, 4'd0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 7'b0000000};
    tbl[14] = '{1'b1, 16'h4340, 1'b1, 1'b0, 4'd0, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 7'b0000000};
    tbl[15] = '{1'b1, 16'h5120, 1'b1, 1'b1, 4'd1, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 7'b0000000};
    tbl[16] = '{1'b1, 16'hC123, 1'b1, 1'b0, 4'd0, 1'b0, 2'd3, 1'b0, 1'b1, 1'b0, 7'b0000000};
    tbl[17] = '{1'b1, 16'hC123, 1'b1, 1'b1, 4'd1, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 7'b0000000};
    tbl[18] = '{1'b1, 16'h0120, 1'b0, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 7'b0000000};
    tbl[19] = '{1'b1, 16'h0120, 1'b0, 1'b1, 4'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 7'b0000000};
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0);
    @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      drive(tbl[k].rst_n, tbl[k].ins, tbl[k].v, tbl[k].mr, tbl[k].rd, tbl[k].bc);
      #2;
      chk($sformatf("v%0d se_sel", k), 32'(se_sel), 32'(tbl[k].se));
      chk($sformatf("v%0d stall", k), 32'(stall), 32'(tbl[k].st));
      chk($sformatf("v%0d flush", k), 32'(flush), 32'(tbl[k].fl));
      chk($sformatf("v%0d md_start", k), 32'(md_start), 32'(tbl[k].ms));
      edge_sync();
      chk($sformatf("v%0d ctrl", k), 32'(ctl()), 32'(tbl[k].ctl));
      chk($sformatf("v%0d halted", k), 32'(halted), 32'd0);
      chk($sformatf("v%0d illegal", k), 32'(illegal), 32'd0);
      @(negedge clk);
    end
    // MULT then DIV: 8 stall cycles with a single start pulse, then issue
    for (int d = 0; d < 2; d++) begin
      drive(1'b1, d ? 16'h0125 : 16'h0124, 1'b1, 1'b0, 4'd0, 1'b0);
      for (int i = 0; i <= 8; i++) begin
        #2;
        chk($sformatf("md%0d c%0d stall", d, i), 32'(stall), 32'(i < 8));
        chk($sformatf("md%0d c%0d start", d, i), 32'(md_start), 32'(i == 0));
        if (i == 0) chk($sformatf("md%0d md_op", d), 32'(md_op), 32'(d));
        edge_sync();
        chk($sformatf("md%0d c%0d ctrl", d, i), 32'(ctl()),
            i == 8 ? (d ? 32'h45 : 32'h44) : 32'h0);
        @(negedge clk);
      end
      drive(1'b1, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0);
      #2;
      chk($sformatf("md%0d after stall", d), 32'(stall), 32'd0);
      edge_sync();
      chk($sformatf("md%0d after ctrl", d), 32'(ctl()), 32'd0);
      @(negedge clk);
    end
    // reset during the fourth wait cycle
    drive(1'b1, 16'h0124, 1'b1, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      edge_sync();
      @(negedge clk);
    end
    drive(1'b0, 16'h0124, 1'b1, 1'b0, 4'd0, 1'b0);
    #2;
    chk("mdrst stall", 32'(stall), 32'd0);
    chk("mdrst start", 32'(md_start), 32'd0);
    edge_sync();
    @(negedge clk);
    drive(1'b1, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      #2;
      chk($sformatf("mdrst post%0d stall", i), 32'(stall), 32'd0);
      chk($sformatf("mdrst post%0d start", i), 32'(md_start), 32'd0);
      edge_sync();
      chk($sformatf("mdrst post%0d ctrl", i), 32'(ctl()), 32'd0);
      @(negedge clk);
    end
    // undefined opcode 1101
    drive(1'b1, 16'hD123, 1'b1, 1'b0, 4'd0, 1'b1);
    #2;
    chk("undef flush", 32'(flush), 32'd0);
    edge_sync();
    chk("undef ctrl", 32'(ctl()), 32'd0);
`ifdef ST2_ILLEGAL_TRAP_EN
    chk("undef illegal", 32'(illegal), 32'd1);
    chk("undef halted", 32'(halted), 32'd1);
`else
    chk("undef illegal", 32'(illegal), 32'd0);
    chk("undef halted", 32'(halted), 32'd0);
`endif
    @(negedge clk);
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0);
    edge_sync();
    chk("undef rst illegal", 32'(illegal), 32'd0);
    chk("undef rst halted", 32'(halted), 32'd0);
    @(negedge clk);
    // HALT is terminal until reset
    drive(1'b1, 16'hF000, 1'b1, 1'b0, 4'd0, 1'b0);
    #2;
    chk("halt entry stall", 32'(stall), 32'd0);
    edge_sync();
    chk("halt halted", 32'(halted), 32'd1);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, i == 1 ? 16'hC123 : 16'h0120, 1'b1, 1'b0, 4'd0, 1'b1);
      #2;
      chk($sformatf("halt%0d stall", i), 32'(stall), 32'd1);
      chk($sformatf("halt%0d flush", i), 32'(flush), 32'd0);
      edge_sync();
      chk($sformatf("halt%0d ctrl", i), 32'(ctl()), 32'd0);
      chk($sformatf("halt%0d halted", i), 32'(halted), 32'd1);
      @(negedge clk);
    end
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0);
    edge_sync();
    chk("halt rst halted", 32'(halted), 32'd0);
    @(negedge clk);
    drive(1'b1, 16'h0120, 1'b1, 1'b0, 4'd0, 1'b0);
    #2;
    chk("halt rst stall", 32'(stall), 32'd0);
    edge_sync();
    chk("halt rst ADD ctrl", 32'(ctl()), 32'h40);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
